// File: rtl/gb_bus_pkg.sv
// Shared definitions for the Game Boy style memory bus: register map defaults,
// OAM DMA FSM encoding and the source-page remap helper.
package gb_bus_pkg;

  localparam logic [15:0] DefDmaRegAddr = 16'hFF46;
  localparam logic [15:0] DefOamBase    = 16'hFE00;
  localparam int unsigned DefDmaLen     = 160;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRead  = 2'd2,
    StWrite = 2'd3
  } dma_state_e;

  // Pages E0-FF alias the echo region onto C0-DF.
  function automatic logic [7:0] eff_src_hi(input logic [7:0] src_hi);
    if (src_hi >= 8'hE0) begin
      return src_hi - 8'h20;
    end
    return src_hi;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine sharing one memory bus with the CPU: copies DMA_LEN bytes from
// page {src_hi, 00} to OAM_BASE, stalling CPU traffic while it owns the bus.
module oam_dma_arbiter
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DefDmaRegAddr,
  parameter logic [15:0] OAM_BASE     = DefOamBase,
  parameter int unsigned DMA_LEN      = DefDmaLen
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_re,
  output logic        bus_we,
  input  logic [7:0]  bus_rdata,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;

  logic       reg_hit;
  logic       reg_wr;
  logic       reg_rd;
  logic       cpu_access;
  logic [7:0] src_eff;

  // Simultaneous re/we is a write, so a register hit with we set never reads.
  assign reg_hit    = (cpu_addr == DMA_REG_ADDR);
  assign cpu_access = cpu_re | cpu_we;
  assign reg_wr     = reg_hit & cpu_we;
  assign reg_rd     = reg_hit & cpu_re & ~cpu_we;
  assign src_eff    = eff_src_hi(src_hi_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      src_hi_q <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    data_d   = data_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StStart: begin
        idx_d   = 8'h00;
        state_d = StRead;
      end
      StRead: begin
        data_d  = bus_rdata;
        state_d = StWrite;
      end
      StWrite: begin
        idx_d = idx_q + 8'h01;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
    // A trigger write restarts from any state and suppresses completion.
    if (reg_wr) begin
      src_hi_d = cpu_wdata;
      idx_d    = 8'h00;
      state_d  = StStart;
      done_d   = 1'b0;
    end
  end

  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_re    = cpu_re & ~cpu_we & ~reg_hit;
    bus_we    = cpu_we & ~reg_hit;
    dma_busy  = 1'b0;
    unique case (state_q)
      StIdle: begin
        dma_busy = 1'b0;
      end
      StStart: begin
        dma_busy  = 1'b1;
        bus_addr  = {src_eff, 8'h00};
        bus_wdata = data_q;
        bus_re    = 1'b0;
        bus_we    = 1'b0;
      end
      StRead: begin
        dma_busy  = 1'b1;
        bus_addr  = {src_eff, idx_q};
        bus_wdata = data_q;
        bus_re    = 1'b1;
        bus_we    = 1'b0;
      end
      StWrite: begin
        dma_busy  = 1'b1;
        bus_addr  = OAM_BASE + {8'h00, idx_q};
        bus_wdata = data_q;
        bus_re    = 1'b0;
        bus_we    = 1'b1;
      end
      default: dma_busy = 1'b0;
    endcase
  end

  assign cpu_stall = dma_busy & cpu_access & ~reg_hit;
  assign cpu_rdata = reg_rd ? src_hi_q : bus_rdata;
  assign dma_done  = done_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: CPU pass-through, full transfers, stalls,
// source remap, restart and asynchronous reset abort.
module tb_oam_dma_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_re;
  logic        bus_we;
  logic [7:0]  bus_rdata;
  logic        dma_busy;
  logic        dma_done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [7:0] oam [0:255];

  oam_dma_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory: every address reads a fixed pattern; OAM page writes are captured.
  assign bus_rdata = pat(bus_addr);

  always @(posedge clock) begin
    if (bus_we && bus_addr[15:8] == 8'hFE) oam[bus_addr[7:0]] <= bus_wdata;
  end

  always @(negedge clock) begin
    if (dma_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic re,
                           input logic we);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_re    = re;
    cpu_we    = we;
  endtask

  task automatic cpu_idle();
    cpu_drive(16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_oam(input logic [15:0] src, input string tag);
    for (int i = 0; i < 160; i++) begin
      chk(tag, {24'h0, oam[i]}, {24'h0, pat(src + 16'(i))});
    end
  endtask

  initial begin
    int n;
    int base_done;

    // Reset state
    #2;
    chk("rst busy", dma_busy, 1'b0);
    chk("rst done", dma_done, 1'b0);
    #20 reset = 1'b1;
    @(posedge clock); #1;
    cpu_drive(16'hFF46, 8'h00, 1'b1, 1'b0); #1;
    chk("rst src_hi", cpu_rdata, 8'h00);
    chk("reg rd no bus_re", bus_re, 1'b0);

    // IDLE pass-through read
    @(posedge clock); #1;
    cpu_drive(16'hC123, 8'h00, 1'b1, 1'b0); #1;
    chk("idle bus_addr", bus_addr, 16'hC123);
    chk("idle bus_re", bus_re, 1'b1);
    chk("idle bus_we", bus_we, 1'b0);
    chk("idle stall", cpu_stall, 1'b0);
    chk("idle rdata", cpu_rdata, pat(16'hC123));

    // Transfer from C1 with stall and register read mid-flight
    @(posedge clock); #1;
    cpu_drive(16'hFF46, 8'hC1, 1'b0, 1'b1); #1;
    chk("trig not forwarded", bus_we, 1'b0);
    chk("trig busy", dma_busy, 1'b0);
    @(posedge clock); #1;
    cpu_idle(); #1;
    n = 0;
    chk("start busy", dma_busy, 1'b1);
    chk("start bus_re", bus_re, 1'b0);
    chk("start bus_we", bus_we, 1'b0);
    while (!dma_done && n < 400) begin
      @(posedge clock); #1;
      n++;
      cpu_idle();
      if (n == 100) cpu_drive(16'hC000, 8'h00, 1'b1, 1'b0);
      if (n == 101) cpu_drive(16'hFF46, 8'h00, 1'b1, 1'b0);
      #1;
      if (n == 1) begin
        chk("c1 first read addr", bus_addr, 16'hC100);
        chk("c1 first read re", bus_re, 1'b1);
      end
      if (n == 2) begin
        chk("c1 first write addr", bus_addr, 16'hFE00);
        chk("c1 first write we", bus_we, 1'b1);
        chk("c1 first write data", bus_wdata, pat(16'hC100));
      end
      if (n == 100) begin
        chk("dma stall", cpu_stall, 1'b1);
        chk("stall bus_addr", bus_addr, 16'hFE31);
        chk("stall bus_re", bus_re, 1'b0);
      end
      if (n == 101) begin
        chk("busy reg rd", cpu_rdata, 8'hC1);
        chk("busy reg stall", cpu_stall, 1'b0);
        chk("busy reg bus_addr", bus_addr, 16'hC132);
      end
    end
    chk("c1 done latency", n, 321);
    @(posedge clock); #1;
    chk("done one cycle", dma_done, 1'b0);
    chk("idle after done", dma_busy, 1'b0);
    chk("c1 done count", done_cnt, 1);
    check_oam(16'hC100, "c1 oam byte");

    // Echo page FE remaps to DE00
    cpu_drive(16'hFF46, 8'hFE, 1'b1, 1'b1); #1;
    chk("both high is write", bus_re, 1'b0);
    @(posedge clock); #1;
    cpu_drive(16'hFF46, 8'h00, 1'b1, 1'b0); #1;
    n = 0;
    chk("fe readback", cpu_rdata, 8'hFE);
    chk("fe readback stall", cpu_stall, 1'b0);
    while (!dma_done && n < 400) begin
      @(posedge clock); #1;
      n++;
      cpu_idle(); #1;
      if (n == 1) chk("fe first read addr", bus_addr, 16'hDE00);
      if (n == 319) chk("fe last read addr", bus_addr, 16'hDE9F);
      if (n == 320) chk("fe last write addr", bus_addr, 16'hFE9F);
    end
    chk("fe done latency", n, 321);
    @(posedge clock); #1;
    chk("fe done count", done_cnt, 2);
    check_oam(16'hDE00, "fe oam byte");

    // Restart at idx 50 with D0
    base_done = done_cnt;
    cpu_drive(16'hFF46, 8'h80, 1'b0, 1'b1);
    @(posedge clock); #1;
    cpu_idle(); #1;
    n = 0;
    while (!dma_done && n < 700) begin
      @(posedge clock); #1;
      n++;
      cpu_idle();
      if (n == 101) cpu_drive(16'hFF46, 8'hD0, 1'b0, 1'b1);
      #1;
      if (n == 1) chk("80 first read addr", bus_addr, 16'h8000);
      if (n == 101) begin
        chk("restart idx50 addr", bus_addr, 16'h8032);
        chk("restart stall", cpu_stall, 1'b0);
        chk("restart not forwarded", bus_we, 1'b0);
      end
      if (n == 102) begin
        chk("restart start busy", dma_busy, 1'b1);
        chk("restart start re", bus_re, 1'b0);
      end
      if (n == 103) chk("restart read addr", bus_addr, 16'hD000);
    end
    chk("restart done latency", n, 423);
    @(posedge clock); #1;
    chk("restart single done", done_cnt, base_done + 1);
    check_oam(16'hD000, "d0 oam byte");

    // Asynchronous reset at idx 80
    base_done = done_cnt;
    cpu_drive(16'hFF46, 8'hC1, 1'b0, 1'b1);
    @(posedge clock); #1;
    cpu_idle(); #1;
    n = 0;
    while (n < 161) begin
      @(posedge clock); #1;
      n++;
    end
    chk("pre-reset busy", dma_busy, 1'b1);
    chk("pre-reset addr", bus_addr, 16'hC150);
    cpu_drive(16'hC123, 8'h00, 1'b1, 1'b0);
    reset = 1'b0; #1;
    chk("async rst busy", dma_busy, 1'b0);
    chk("async rst bus_addr", bus_addr, 16'hC123);
    chk("async rst bus_re", bus_re, 1'b1);
    chk("async rst stall", cpu_stall, 1'b0);
    chk("async rst done", dma_done, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    cpu_drive(16'hFF46, 8'h00, 1'b1, 1'b0); #1;
    chk("post-rst src_hi", cpu_rdata, 8'h00);
    repeat (5) @(posedge clock);
    #1;
    chk("post-rst busy", dma_busy, 1'b0);
    chk("post-rst no done", done_cnt, base_done);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, 16'hFF46, CPU address of the DMA trigger register.
REQ-002 SHALL have parameter OAM_BASE, 16'hFE00, destination base address.
REQ-003 SHALL have parameter DMA_LEN, 160, bytes per transfer.
REQ-004 SHALL have port clock  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_addr in 16, cpu_wdata in 8, cpu_re in 1, cpu_we in 1: CPU bus request.
REQ-007 SHALL have ports cpu_rdata out 8 and cpu_stall out 1: CPU read data and wait request.
REQ-008 SHALL have ports bus_addr out 16, bus_wdata out 8, bus_re out 1, bus_we out 1, bus_rdata in 8: shared memory bus.
REQ-009 SHALL have ports dma_busy out 1, DMA owns bus; dma_done out 1, one-cycle completion pulse.

Function
REQ-010 SHALL be an FSM with states IDLE, START, READ, WRITE.
REQ-011 IDLE: bus ports combinationally mirror CPU ports; cpu_rdata = bus_rdata; cpu_stall = 0.
REQ-012 CPU write with cpu_addr == DMA_REG_ADDR SHALL latch cpu_wdata into src_hi, SHALL NOT be forwarded (bus_we = 0), and SHALL move FSM to START on the next edge.
REQ-013 CPU read of DMA_REG_ADDR SHALL return src_hi on cpu_rdata with bus_re = 0, in any state, without stall.
REQ-014 src_hi values 8'hE0-8'hFF SHALL be used as src_hi - 8'h20 for addressing; register readback returns unmodified value.
REQ-015 START: one idle bus cycle, byte index idx cleared to 0, dma_busy = 1.
REQ-016 READ: bus_addr = {src_hi_eff, idx}, bus_re = 1; bus_rdata captured into data_reg at the clock edge ending READ.
REQ-017 WRITE: bus_addr = OAM_BASE + idx, bus_wdata = data_reg, bus_we = 1; idx increments at end of WRITE.
REQ-018 After WRITE with idx == DMA_LEN-1 SHALL go to IDLE and pulse dma_done for the first IDLE cycle; otherwise go to READ.
REQ-019 Transfer SHALL occupy exactly 1 + 2*DMA_LEN = 321 cycles from START entry to IDLE entry.
REQ-020 dma_busy SHALL be 1 in START, READ, WRITE; 0 in IDLE.
REQ-021 While dma_busy, any cpu_re/cpu_we not addressing DMA_REG_ADDR SHALL assert cpu_stall and SHALL NOT reach the bus.
REQ-022 CPU write to DMA_REG_ADDR while busy SHALL update src_hi and restart at START (idx = 0); no dma_done for the aborted transfer.
REQ-023 cpu_re and cpu_we both high SHALL be treated as write.
REQ-024 idx SHALL be 8 bits; OAM_BASE + idx computed in 16 bits, no wrap for DMA_LEN <= 256.

Reset
REQ-025 Asserting reset (low) SHALL asynchronously force state IDLE, src_hi 8'h00, idx 0, data_reg 0, dma_done 0, dma_busy 0.
REQ-026 Reset mid-transfer SHALL abort it; no dma_done; bus outputs follow CPU ports immediately.
REQ-027 Release of reset SHALL take effect on the next rising clock edge.

Structure
REQ-028 State encoding localparams and DMA_REG_ADDR/OAM_BASE/DMA_LEN defaults SHALL live in shared package gb_bus_pkg.
REQ-029 Single module; no sub-modules; FSM and datapath in one file.

Verification
REQ-030 Bench SHALL cover: IDLE, CPU read 16'hC123 -> bus_addr 16'hC123, bus_re 1, cpu_stall 0, cpu_rdata = bus_rdata.
REQ-031 Bench SHALL cover: write 8'hC1 to FF46 -> bus reads C100..C19F copied to FE00..FE9F, dma_done pulse exactly 321 cycles after START entry.
REQ-032 Bench SHALL cover: CPU read 16'hC000 during DMA -> cpu_stall 1, bus_addr stays DMA-driven; read FF46 -> cpu_rdata 8'hC1, no stall.
REQ-033 Bench SHALL cover: write 8'hFE to FF46 -> source reads DE00..DE9F; FF46 readback 8'hFE.
REQ-034 Bench SHALL cover: at idx 50 write 8'hD0 to FF46 -> restart, reads D000 onward, one dma_done only.
REQ-035 Bench SHALL cover: reset low at idx 80 -> dma_busy 0 asynchronously, no dma_done, src_hi reads 8'h00.
